apb_master_arbiter: RTL

- Shares one APB master port between N_REQ on-chip requesters, e.g. a DMAC config sequencer and a debug/test port.
- Each requester issues single transfers on a valid/ready command channel. The block arbitrates round-robin and runs the APB SETUP/ACCESS phases.
- It returns read data and error status on a per-requester response pulse.
- It sits between the requesters and the APB slave register file, such as the DMAC CFG block.

---
 rtl/apb_arb_pkg.sv | 20 ++
 rtl/apb_master_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/apb_master_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Optional build macro used by the arbiter: APB_TIMEOUT_EN (ACCESS-phase wait limit).
// Index widths are derived from the requester count through idx_width().
package apb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Requester count used when a module is not overridden.
  localparam int unsigned N_REQ_DEF = 2;

  // Index width for n requesters; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester command/response channel plus the APB master port of the arbiter.
// master: arbiter side; slave: requesters and APB register file side.
// Per-requester fields are flattened, requester r at slice [r*W +: W].
interface apb_master_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*ADDR_W-1:0] req_addr_i;
  logic [N_REQ-1:0]        req_write_i;
  logic [N_REQ*DATA_W-1:0] req_wdata_i;

  logic [N_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]       rsp_rdata_o;
  logic                    rsp_slverr_o;

  logic                    psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [ADDR_W-1:0]       paddr_o;
  logic [DATA_W-1:0]       pwdata_o;
  logic                    pready_i;
  logic [DATA_W-1:0]       prdata_i;
  logic                    pslverr_i;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i,
    input  pready_i, prdata_i, pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_slverr_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i,
    output pready_i, prdata_i, pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_slverr_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
// Purely combinational; the rotating pointer lives in the parent.
// gnt is one-hot (or zero when nothing is requested).
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Walk the requesters from ptr upward, first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      pos = sum[IDX_W-1:0];
      if (!gnt_any && req[pos]) begin
        gnt_any  = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between N_REQ requesters, round-robin, single transfers.
// Latency: accept, SETUP, ACCESS (+ slave wait states), then one response cycle.
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles with an error.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  apb_master_arbiter_if.master bus
);

  localparam int IDX_W = idx_width(N_REQ);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  cur;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_slverr_q;

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              to_hit;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (bus.req_valid_i),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // A grant is only taken in IDLE, outside reset, and never in the response cycle.
  assign accept          = (state == S_IDLE) && !rst && (rsp_valid_q == '0) && gnt_any;
  assign bus.req_ready_o = accept ? gnt : '0;

  assign bus.psel_o       = psel_q;
  assign bus.penable_o    = penable_q;
  assign bus.pwrite_o     = pwrite_q;
  assign bus.paddr_o      = paddr_q;
  assign bus.pwdata_o     = pwdata_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_rdata_o  = rsp_rdata_q;
  assign bus.rsp_slverr_o = rsp_slverr_q;

  // Select the winning requester's payload out of the flattened buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr  = bus.req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata_i[i*DATA_W +: DATA_W];
        sel_write = bus.req_write_i[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  // Fires in the last allowed ACCESS cycle if the slave is still not ready.
  assign to_hit = !bus.pready_i && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // Transfer sequencer: IDLE -> SETUP -> ACCESS -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      cur          <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_SETUP;
            cur      <= gnt_idx;
            ptr      <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            paddr_q  <= sel_addr;
            pwdata_q <= sel_wdata;
            pwrite_q <= sel_write;
            psel_q   <= 1'b1;
          end
        end
        S_SETUP: begin
          state     <= S_ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          to_cnt    <= '0;
`endif
        end
        S_ACCESS: begin
          if (bus.pready_i || to_hit) begin
            state            <= S_IDLE;
            psel_q           <= 1'b0;
            penable_q        <= 1'b0;
            rsp_valid_q      <= '0;
            rsp_valid_q[cur] <= 1'b1;
            if (to_hit) begin
              rsp_rdata_q  <= '0;
              rsp_slverr_q <= 1'b1;
            end else begin
              rsp_rdata_q  <= pwrite_q ? '0 : bus.prdata_i;
              rsp_slverr_q <= bus.pslverr_i;
            end
          end
`ifdef APB_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
